hlsm_launcher: RTL and testbench



---
 rtl/hlsm_launcher.sv | 163 ++++++++++++++++
 tb/tb_hlsm_launcher.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hlsm_launcher.sv
// Start/Done initiator for one HLSM kernel: takes operand sets over
// valid/ready, holds Start for the whole schedule, returns z/x/latency.
// Ports:
//   Clk, Rst (sync, active-low)
//   in_valid/in_ready, in_a/in_b/in_c/in_one : operand input handshake
//   k_Rst, k_Start, k_a..k_one               : kernel drive
//   k_Done, k_z, k_x                         : kernel response
//   out_valid/out_ready, out_z, out_x,
//   out_cycles, out_timeout                  : result output handshake
module hlsm_launcher #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic [DATA_W-1:0] in_one,
    output logic              k_Rst,
    output logic              k_Start,
    output logic [DATA_W-1:0] k_a,
    output logic [DATA_W-1:0] k_b,
    output logic [DATA_W-1:0] k_c,
    output logic [DATA_W-1:0] k_one,
    input  logic              k_Done,
    input  logic [DATA_W-1:0] k_z,
    input  logic [DATA_W-1:0] k_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_z,
    output logic [DATA_W-1:0] out_x,
    output logic [CNT_W-1:0]  out_cycles,
    output logic              out_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        RECOVER,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d, one_q, one_d;
    logic [DATA_W-1:0] z_q, z_d, x_q, x_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              to_q, to_d;
    logic              start_c;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        one_d   = one_q;
        z_d     = z_q;
        x_d     = x_q;
        cyc_d   = cyc_q;
        to_d    = to_q;
        start_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    c_d     = in_c;
                    one_d   = in_one;
                    cnt_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                // Done may be stale from the previous run; ignore it here.
                start_c = 1'b1;
                cnt_d   = cnt_inc;
                state_d = RUN;
            end
            RUN: begin
                // cnt_q counts Start-high cycles so far; once it reaches
                // TIMEOUT this is the decision cycle, so Start drops.
                start_c = ~k_Done & (cnt_q != TO_C);
                if (k_Done) begin
                    z_d     = k_z;
                    x_d     = k_x;
                    cyc_d   = cnt_q;
                    to_d    = 1'b0;
                    state_d = HOLD;
                end else if (cnt_q == TO_C) begin
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RECOVER: begin
                z_d     = '0;
                x_d     = '0;
                cyc_d   = TO_C;
                to_d    = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            one_q   <= '0;
            z_q     <= '0;
            x_q     <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            one_q   <= one_d;
            z_q     <= z_d;
            x_q     <= x_d;
            cyc_q   <= cyc_d;
            to_q    <= to_d;
        end
    end

    // Kernel is reset in the same cycle as the launcher, and never
    // started while the launcher itself is held in reset.
    assign k_Rst       = ~Rst | (state_q == RECOVER);
    assign k_Start     = start_c & Rst;
    assign k_a         = a_q;
    assign k_b         = b_q;
    assign k_c         = c_q;
    assign k_one       = one_q;
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == HOLD);
    assign out_z       = z_q;
    assign out_x       = x_q;
    assign out_cycles  = cyc_q;
    assign out_timeout = to_q;

endmodule

// File: tb/tb_hlsm_launcher.sv
// Directed bench for hlsm_launcher with a behavioral HLSM kernel model
// (z=a+b, x=a-b after a configurable number of Start edges, or hung).
module tb_hlsm_launcher;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0, in_c = '0, in_one = '0;
    logic        k_Rst, k_Start;
    logic [31:0] k_a, k_b, k_c, k_one;
    logic        k_Done = 1'b0;
    logic [31:0] k_z = '0, k_x = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z, out_x;
    logic [15:0] out_cycles;
    logic        out_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    int klat = 12;
    bit hang = 1'b0;
    int kcnt = 0;
    int starts = 0;
    int accepts = 0;
    int relaunch = 0;
    bit tb_arm = 1'b0;

    hlsm_launcher #(.DATA_W(32), .CNT_W(16), .TIMEOUT(64)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_one(in_one),
        .k_Rst(k_Rst), .k_Start(k_Start),
        .k_a(k_a), .k_b(k_b), .k_c(k_c), .k_one(k_one),
        .k_Done(k_Done), .k_z(k_z), .k_x(k_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_x(out_x),
        .out_cycles(out_cycles), .out_timeout(out_timeout)
    );

    always #5 Clk = ~Clk;

    // Kernel model: Done stays high until the next Start is seen.
    always @(posedge Clk) begin
        if (k_Rst) begin
            kcnt   <= 0;
            k_Done <= 1'b0;
        end else if (k_Start) begin
            if (k_Done || kcnt == 0) starts <= starts + 1;
            if (k_Done) begin
                k_Done <= 1'b0;
                kcnt   <= 1;
            end else if (!hang && kcnt == klat - 1) begin
                k_Done <= 1'b1;
                kcnt   <= 0;
                k_z    <= k_a + k_b;
                k_x    <= k_a - k_b;
            end else begin
                kcnt <= kcnt + 1;
            end
        end
    end

    always @(posedge Clk) begin
        tb_arm <= in_valid && in_ready && Rst;
        if (in_valid && in_ready && Rst) accepts <= accepts + 1;
    end

    always @(negedge Clk)
        if (Rst && k_Done && k_Start && !tb_arm) relaunch <= relaunch + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
    endtask

    int n, sh, rh;
    bit bad;

    initial begin
        // Reset
        tick(); tick(); tick();
        chk("rst_k_Rst", k_Rst, 1);
        chk("rst_k_Start", k_Start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_out_cycles", out_cycles, 0);
        chk("rst_k_a", k_a, 0);
        Rst = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_k_Rst", k_Rst, 0);

        // Basic run
        in_a = 5; in_b = 7; in_c = 2; in_one = 1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("arm_k_Start", k_Start, 1);
        chk("arm_k_a", k_a, 5);
        chk("arm_k_one", k_one, 1);
        chk("arm_in_ready", in_ready, 0);
        wait_out(n);
        chk("b1_valid", out_valid, 1);
        chk("b1_latency", n, 13);
        chk("b1_z", out_z, 12);
        chk("b1_x", out_x, 32'hFFFF_FFFE);
        chk("b1_cycles", out_cycles, 12);
        chk("b1_timeout", out_timeout, 0);
        chk("b1_in_ready", in_ready, 0);

        // Backpressure with new operands offered
        in_a = 100; in_b = 1; in_c = 3; in_one = 1; in_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_z !== 12 || out_x !== 32'hFFFF_FFFE ||
                out_cycles !== 12 || k_a !== 5 || k_Start !== 1'b0)
                bad = 1'b1;
        end
        chk("bp_stable", bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_out_valid", out_valid, 0);
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_no_early_accept", k_a, 5);

        // Second run: Done still high from the first run
        tick();
        in_valid = 1'b0;
        chk("b2_k_a", k_a, 100);
        chk("b2_stale_done", k_Done, 1);
        chk("b2_arm_start", k_Start, 1);
        wait_out(n);
        chk("b2_latency", n, 13);
        chk("b2_z", out_z, 101);
        chk("b2_x", out_x, 99);
        chk("b2_cycles", out_cycles, 12);

        // Third run back to back, out_ready held high
        in_a = 32'hFFFF_FFFD; in_b = 4; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("b3_turn_idle", in_ready, 1);
        chk("b3_turn_nv", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("b3_arm_start", k_Start, 1);
        wait_out(n);
        chk("b3_latency", n, 13);
        chk("b3_z", out_z, 1);
        chk("b3_x", out_x, 32'hFFFF_FFF9);
        chk("b3_cycles", out_cycles, 12);
        tick();
        out_ready = 1'b0;
        chk("b3_back_idle", in_ready, 1);

        // Hung kernel
        hang = 1'b1;
        in_a = 9; in_b = 9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0; sh = 0; rh = 0;
        while (!out_valid && n < 300) begin
            if (k_Start) sh++;
            if (k_Rst) rh++;
            tick();
            n++;
        end
        chk("hang_valid", out_valid, 1);
        chk("hang_start_cycles", sh, 64);
        chk("hang_krst_pulse", rh, 1);
        chk("hang_latency", n, 66);
        chk("hang_timeout", out_timeout, 1);
        chk("hang_z", out_z, 0);
        chk("hang_x", out_x, 0);
        chk("hang_cycles", out_cycles, 64);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        hang = 1'b0;

        // Done coincides with counter reaching TIMEOUT
        klat = 64;
        in_a = 1; in_b = 2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(n);
        chk("edge_latency", n, 65);
        chk("edge_timeout", out_timeout, 0);
        chk("edge_cycles", out_cycles, 64);
        chk("edge_z", out_z, 3);
        chk("edge_x", out_x, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a run
        klat = 12;
        in_a = 7; in_b = 1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mr_running", k_Start, 1);
        Rst = 1'b0;
        #1;
        chk("mr_k_Rst", k_Rst, 1);
        chk("mr_k_Start", k_Start, 0);
        tick();
        chk("mr_idle", in_ready, 1);
        chk("mr_cycles_clr", out_cycles, 0);
        chk("mr_k_a_clr", k_a, 0);
        tick();
        Rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        chk("mr_no_result", bad, 0);

        // Global kernel-side properties
        chk("no_relaunch", relaunch, 0);
        chk("accepts", accepts, 6);
        chk("starts_per_accept", starts, accepts);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
